// File: rtl/disp_scan_mux.sv
// Four-digit common-anode seven-segment scan driver with frame-synchronous value commit.
// Optional leading-zero suppression is compiled in with DISP_LZ_BLANK_EN.
module disp_scan_mux #(
   parameter int DIV_W = 16,
   parameter int GUARD = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        load,
   input  logic [3:0]  digit_en,
   output logic [3:0]  D,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);

   logic [DIV_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      pending;
   logic             pendingValid;
   logic [15:0]      shadow;
   logic             tick;
   logic             commit;
   logic [3:0]       show;

   assign tick   = &cnt;
   assign commit = tick && (idx == 2'd3);

`ifdef DISP_LZ_BLANK_EN
   // A digit is blank only when it and every more significant digit are zero.
   assign show[3] = digit_en[3] && (shadow[15:12] != 4'h0);
   assign show[2] = digit_en[2] && (shadow[15:8]  != 8'h00);
   assign show[1] = digit_en[1] && (shadow[15:4]  != 12'h000);
   assign show[0] = digit_en[0];
`else
   assign show = digit_en;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         idx          <= 2'd0;
         pending      <= 16'h0000;
         pendingValid <= 1'b0;
         shadow       <= 16'h0000;
         D            <= 4'h0;
         an           <= 4'b1111;
         frame_start  <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;

         // A load on the commit tick bypasses pending so it still lands in the next frame.
         if (commit) begin
            if (load)
               shadow <= value;
            else if (pendingValid)
               shadow <= pending;
            pendingValid <= 1'b0;
         end else if (load) begin
            pending      <= value;
            pendingValid <= 1'b1;
         end

         D <= shadow[{idx, 2'b00} +: 4];
         if ((cnt < GUARD_C) || !show[idx])
            an <= 4'b1111;
         else
            an <= ~(4'b0001 << idx);
         frame_start <= commit;
      end
   end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux with DIV_W=3, GUARD=2 (8-clock slots, 32-clock frames).
module tb_disp_scan_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic        load;
   logic [3:0]  digit_en;
   logic [3:0]  D;
   logic [3:0]  an;
   logic        frame_start;

   int passCnt = 0;
   int totalCnt = 0;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  en;
      logic [15:0] expD;
      logic [15:0] expAn;
   } vec_t;

   localparam logic [15:0] AN_ALL  = 16'h7BDE;
   localparam logic [15:0] AN_0101 = 16'hFBFE;
`ifdef DISP_LZ_BLANK_EN
   localparam logic [15:0] AN_ZERO = 16'hFFFE;
   localparam logic [15:0] AN_0040 = 16'hFFDE;
`else
   localparam logic [15:0] AN_ZERO = 16'h7BDE;
   localparam logic [15:0] AN_0040 = 16'h7BDE;
`endif

   vec_t vecs [5];
   vec_t zeroVec;

   disp_scan_mux #(.DIV_W(3), .GUARD(2)) dut (
      .clk(clk),
      .reset(reset),
      .value(value),
      .load(load),
      .digit_en(digit_en),
      .D(D),
      .an(an),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      totalCnt++;
      if (act === exp)
         passCnt++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Entered at a negedge just before the first edge of a frame; samples all 32 output cycles.
   task automatic checkFrame(input vec_t e, input int at1, input logic [15:0] lv1,
                             input int at2, input logic [15:0] lv2);
      digit_en = e.en;
      for (int k = 0; k < 32; k++) begin
         int s;
         int c;
         @(negedge clk);
         s = k / 8;
         c = k % 8;
         chk($sformatf("D s%0d c%0d", s, c), {12'h0, D}, {12'h0, e.expD[4*s +: 4]});
         chk($sformatf("an s%0d c%0d", s, c), {12'h0, an},
             (c < 2) ? 16'h000F : {12'h0, e.expAn[4*s +: 4]});
         chk($sformatf("frame_start k%0d", k), {15'h0, frame_start}, {15'h0, k == 31});
         load = 1'b0;
         if (k == at1) begin
            load  = 1'b1;
            value = lv1;
         end else if (k == at2) begin
            load  = 1'b1;
            value = lv2;
         end
      end
   endtask

   task automatic checkReset();
      chk("reset D", {12'h0, D}, 16'h0000);
      chk("reset an", {12'h0, an}, 16'h000F);
      chk("reset frame_start", {15'h0, frame_start}, 16'h0000);
   endtask

   initial begin
      vec_t v2222;
      vec_t v3333;
      zeroVec  = '{16'h0000, 4'hF, 16'h0000, AN_ZERO};
      vecs[0]  = zeroVec;
      vecs[1]  = '{16'h1A2F, 4'hF, 16'h1A2F, AN_ALL};
      vecs[2]  = '{16'h8421, 4'h5, 16'h8421, AN_0101};
      vecs[3]  = '{16'h0040, 4'hF, 16'h0040, AN_0040};
      vecs[4]  = '{16'h0000, 4'hF, 16'h0000, AN_ZERO};
      v2222    = '{16'h2222, 4'hF, 16'h2222, AN_ALL};
      v3333    = '{16'h3333, 4'hF, 16'h3333, AN_ALL};

      reset    = 1'b1;
      load     = 1'b0;
      value    = 16'h0000;
      digit_en = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkReset();
      reset = 1'b0;

      // Each frame checks the value committed last frame while loading the next one mid-frame.
      for (int i = 0; i < 5; i++)
         checkFrame(vecs[i], (i < 4) ? 10 : -1, (i < 4) ? vecs[(i < 4) ? i + 1 : i].val : 16'h0,
                    -1, 16'h0);

      // Two loads in one frame: last wins.
      checkFrame(zeroVec, 3, 16'h1111, 20, 16'h2222);
      // Load coinciding with the commit tick goes straight to the next frame.
      checkFrame(v2222, 30, 16'h3333, -1, 16'h0);
      checkFrame(v3333, -1, 16'h0, -1, 16'h0);

      // Pending load at idx 1, then reset during slot 2: pending must be dropped.
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         load  = (k == 10);
         value = 16'h5555;
      end
      load  = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkReset();
      reset = 1'b0;
      checkFrame(zeroVec, -1, 16'h0, -1, 16'h0);
      checkFrame(zeroVec, -1, 16'h0, -1, 16'h0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
